// File: rtl/pam_rx_pkg.sv
// Shared PAM receive types and constants: gain FSM states, gain shift width, lock threshold helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pam_rx_pkg;

  // Width of the gain_shift field (covers shifts 0..7).
  localparam int GAIN_SHIFT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CALC = 2'd2
  } gain_state_t;

  // A pilot is considered usable once its corrected mean reaches 3/4 of the
  // nominal unattenuated mean.
  function automatic int lock_thresh(input int pilot_ref);
    return (3 * pilot_ref) / 4;
  endfunction

endpackage

// File: rtl/sat_shift.sv
// Signed arithmetic left shift with clamp to the W-bit two's complement range; flags when clamping occurred.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
// Ports: din (W-bit signed sample), shift (0..MAX_SHIFT), dout (clamped result), clamp (1 when dout was limited).
module sat_shift
  import pam_rx_pkg::*;
#(
  parameter int W         = 12,
  parameter int MAX_SHIFT = 3
) (
  input  logic signed [W-1:0]            din,
  input  logic        [GAIN_SHIFT_W-1:0] shift,
  output logic signed [W-1:0]            dout,
  output logic                           clamp
);

  localparam int WW = W + MAX_SHIFT;

  // Range limits expressed in the widened domain.
  localparam logic signed [WW-1:0] SAT_MAX = {{(MAX_SHIFT+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(MAX_SHIFT+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] shifted;

  always_comb begin
    // Headroom of MAX_SHIFT bits means the shift itself can never wrap.
    ext     = {{MAX_SHIFT{din[W-1]}}, din};
    shifted = ext <<< shift;
    clamp   = 1'b0;
    dout    = shifted[W-1:0];
    if (shifted > SAT_MAX) begin
      dout  = SAT_MAX[W-1:0];
      clamp = 1'b1;
    end else if (shifted < SAT_MIN) begin
      dout  = SAT_MIN[W-1:0];
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/pilot_gain_eq.sv
// Pilot-driven power-of-two gain equalizer: averages |x| over a pilot window, picks a shift, applies it with saturation.
// Latency: 1 cycle sample-in to sample-out; new gain applies to the first sample after the CALC cycle.
// Backpressure: none; consumes every valid sample, output valid mirrors input valid one cycle later.
// Ports: clk, rst (sync, active-high); data_in/data_in_vld sample in; pilot_start marks first pilot sample;
//        data_out/data_out_vld corrected sample; gain_shift/gain_lock/pilot_fail estimate status;
//        sat_cnt clamp counter, present only when PILOT_GAIN_SAT_CNT_EN is defined.
module pilot_gain_eq
  import pam_rx_pkg::*;
#(
  parameter int AD_CVER_WIDTH = 12,
  parameter int PILOT_LEN     = 16,
  parameter int PILOT_REF     = 1024,
  parameter int MAX_SHIFT     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [AD_CVER_WIDTH-1:0] data_in,
  input  logic                            data_in_vld,
  input  logic                            pilot_start,
  output logic signed [AD_CVER_WIDTH-1:0] data_out,
  output logic                            data_out_vld,
  output logic        [GAIN_SHIFT_W-1:0]  gain_shift,
  output logic                            gain_lock,
  output logic                            pilot_fail
`ifdef PILOT_GAIN_SAT_CNT_EN
  ,output logic       [15:0]              sat_cnt
`endif
);

  localparam int W        = AD_CVER_WIDTH;
  localparam int LOG2_LEN = $clog2(PILOT_LEN);
  localparam int ACC_W    = W + 1 + LOG2_LEN;
  localparam int CNT_W    = LOG2_LEN + 1;
  localparam int THRESH   = lock_thresh(PILOT_REF);

  gain_state_t              state, state_nxt;
  logic [ACC_W-1:0]         acc, acc_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [GAIN_SHIFT_W-1:0]  shift_nxt;
  logic                     lock_nxt, fail_nxt;
  logic                     start_acc;
  logic [W:0]               mag;
  logic [W:0]               mean;
  logic signed [W-1:0]      sat_y;
  logic                     sat_clamp;

  // |x| in W+1 bits so the most-negative sample maps to +2^(W-1).
  always_comb begin
    mag = {data_in[W-1], data_in};
    if (data_in[W-1]) mag = ~mag + 1'b1;
  end

  assign mean = acc[ACC_W-1:LOG2_LEN];

  sat_shift #(
    .W         (W),
    .MAX_SHIFT (MAX_SHIFT)
  ) u_sat_shift (
    .din   (data_in),
    .shift (gain_shift),
    .dout  (sat_y),
    .clamp (sat_clamp)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    shift_nxt = gain_shift;
    lock_nxt  = gain_lock;
    fail_nxt  = pilot_fail;
    start_acc = 1'b0;
    case (state)
      IDLE, ACC: begin
        if (pilot_start) begin
          // A new pilot (also a restart mid-ACC) seeds from the current sample.
          start_acc = 1'b1;
          state_nxt = ACC;
          acc_nxt   = data_in_vld ? ACC_W'(mag) : '0;
          cnt_nxt   = data_in_vld ? CNT_W'(1) : '0;
        end else if (state == ACC && data_in_vld) begin
          acc_nxt = acc + ACC_W'(mag);
          cnt_nxt = cnt + 1'b1;
        end
        if (state_nxt == ACC && cnt_nxt == CNT_W'(PILOT_LEN)) state_nxt = CALC;
      end
      CALC: begin
        shift_nxt = GAIN_SHIFT_W'(MAX_SHIFT);
        lock_nxt  = 1'b0;
        fail_nxt  = 1'b1;
        // Descending scan so the smallest qualifying shift is the one kept.
        for (int s = MAX_SHIFT; s >= 0; s--) begin
          if (({{(31-W){1'b0}}, mean} << s) >= 32'(THRESH)) begin
            shift_nxt = GAIN_SHIFT_W'(s);
            lock_nxt  = 1'b1;
            fail_nxt  = 1'b0;
          end
        end
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      gain_shift <= '0;
      gain_lock  <= 1'b0;
      pilot_fail <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      gain_shift <= shift_nxt;
      gain_lock  <= lock_nxt;
      pilot_fail <= fail_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      data_out_vld <= 1'b0;
    end else begin
      data_out_vld <= data_in_vld;
      if (data_in_vld) data_out <= sat_y;
    end
  end

`ifdef PILOT_GAIN_SAT_CNT_EN
  // Clear wins over a clamp on the accepting cycle; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      sat_cnt <= '0;
    end else if (data_in_vld && sat_clamp && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic sat_unused;
  assign sat_unused = sat_clamp ^ start_acc;
`endif

endmodule

// File: tb/tb_pilot_gain_eq.sv
module tb_pilot_gain_eq;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [11:0] data_in = '0;
  logic               data_in_vld = 1'b0;
  logic               pilot_start = 1'b0;
  logic signed [11:0] data_out;
  logic               data_out_vld;
  logic [2:0]         gain_shift;
  logic               gain_lock;
  logic               pilot_fail;
`ifdef PILOT_GAIN_SAT_CNT_EN
  logic [15:0]        sat_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pilot_gain_eq dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_vld  (data_in_vld),
    .pilot_start  (pilot_start),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .gain_shift   (gain_shift),
    .gain_lock    (gain_lock),
    .pilot_fail   (pilot_fail)
`ifdef PILOT_GAIN_SAT_CNT_EN
    ,.sat_cnt     (sat_cnt)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic drive(input bit vld, input int d, input bit ps);
    data_in     = 12'(d);
    data_in_vld = vld;
    pilot_start = ps;
    @(negedge clk);
  endtask

  // Alternating +amp/-amp pilot; optional invalid gap cycles between samples.
  task automatic pilot(input int amp, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) drive(1'b0, 999, 1'b0);
      drive(1'b1, (i % 2) ? -amp : amp, i == 0);
    end
  endtask

  task automatic chk_gain(input string tag, input int sh, input int lk, input int fl);
    chk({tag, "_shift"}, int'(gain_shift), sh);
    chk({tag, "_lock"},  int'(gain_lock),  lk);
    chk({tag, "_fail"},  int'(pilot_fail), fl);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dout"}, int'(data_out), 0);
    chk({tag, "_vld"},  int'(data_out_vld), 0);
    chk_gain(tag, 0, 0, 0);
`ifdef PILOT_GAIN_SAT_CNT_EN
    chk({tag, "_satcnt"}, int'(sat_cnt), 0);
`endif
  endtask

  initial begin
    @(negedge clk);
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 100, 1'b1);
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    chk_reset("reset");

    // +-512: 512<<1 = 1024 >= 768 -> shift 1
    pilot(512, 16, 1'b0);
    chk("pilot_passthru", int'(data_out), -512);
    drive(1'b1, 300, 1'b0);               // sample in CALC uses old shift
    chk("calc_old_shift", int'(data_out), 300);
    chk_gain("p512", 1, 1, 0);
    drive(1'b1, 300, 1'b0);
    chk("gain1_out", int'(data_out), 600);
    chk("gain1_vld", int'(data_out_vld), 1);
    drive(1'b0, 5, 1'b0);
    chk("idle_vld", int'(data_out_vld), 0);
    chk("idle_hold", int'(data_out), 600);

    pilot(1024, 16, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("p1024", 0, 1, 0);

    pilot(128, 16, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("p128", 3, 1, 0);

    pilot(0, 16, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("pzero", 3, 0, 1);

    // Back to shift 0 so the next pilot passes through unclamped.
    pilot(1024, 16, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("p1024b", 0, 1, 0);

    pilot(256, 16, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("p256", 2, 1, 0);
    drive(1'b1, 700, 1'b0);
    chk("sat_pos", int'(data_out), 2047);
    drive(1'b1, -1000, 1'b0);
    chk("sat_neg", int'(data_out), -2048);
    drive(1'b1, -300, 1'b0);
    chk("gain2_neg", int'(data_out), -1200);
`ifdef PILOT_GAIN_SAT_CNT_EN
    chk("sat_cnt", int'(sat_cnt), 2);
`endif

    // Restart after 10 samples of +-1024: only the last 16 of +-256 count.
    pilot(1024, 10, 1'b0);
    pilot(256, 16, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("restart", 2, 1, 0);

    // 50% valid duty cycle; invalid cycles carry junk data.
    pilot(128, 16, 1'b1);
    drive(1'b0, 0, 1'b0);
    chk_gain("gaps", 3, 1, 0);

    // Abort mid-pilot with reset; pilot_start alongside rst must be ignored.
    pilot(512, 8, 1'b0);
    rst = 1'b1;
    drive(1'b1, 512, 1'b1);
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    chk_reset("midrst");
    for (int i = 0; i < 16; i++) drive(1'b1, (i % 2) ? -128 : 128, 1'b0);
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("no_start", 0, 0, 0);

    pilot(512, 16, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_gain("after_rst", 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
